arith_accum: RTL and testbench
==============================

# arith_accum

Block accumulator placed directly downstream of the `arith` adder/multiplier stage. It consumes the `Sum`/`Product` result pairs that stage produces, one pair per valid/ready handshake, and keeps two running totals over a block of `block_len` accepted pairs. It then presents the totals on a held output handshake and returns to idle once they are taken. Widths track the upstream `size_adder`/`size_mult` parameters so the two stages chain without glue.

## Interface
- `size_adder`, default 4: upstream adder operand width; `Sum` is `size_adder+1` bits.
- `size_mult`, default 4: upstream multiplier operand width; `Product` is `2*size_mult` bits.
- `block_len`, default 4: pairs per block, must be ≥1.
- `guard`, default 2: extra accumulator headroom bits.
- Derived widths:
  - SW = `size_adder+1+guard`.
  - PW = `2*size_mult+guard`.
  - CW = `$clog2(block_len)+1`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `Sum`/`Product` pair offered.
- `in_ready`  out  1  block can accept a pair.
- `Sum`  in  `size_adder+1`  upstream sum, unsigned.
- `Product`  in  `2*size_mult`  upstream product, unsigned.
- `clear`  in  1  synchronous abort of the partial block.
- `out_valid`  out  1  block totals available.
- `out_ready`  in  1  consumer takes the totals.
- `sum_acc`  out  SW  running/final sum total.
- `prod_acc`  out  PW  running/final product total.
- `count`  out  CW  pairs accepted in the current block.
- `ovf`  out  1  sticky overflow for the current block.

## Operation
- Design has one clock and one reset: `clk`, with `rst` synchronous and active-high.
- Accept means `in_valid && in_ready` at a rising edge. Output handshake means `out_valid && out_ready` at a rising edge.
- States:
  - IDLE: no pair accepted yet.
  - ACCUM: partial block.
  - HOLD: totals presented.
- `in_ready` = (state != HOLD), decoded combinationally from state. `out_valid` = (state == HOLD).
- IDLE:
  - On accept: load `sum_acc`=`Sum` and `prod_acc`=`Product`, both zero-extended.
  - Set `count`=1 and clear `ovf`.
  - Next state is ACCUM, or HOLD if `block_len`==1.
- ACCUM:
  - On accept: `sum_acc`+=`Sum`, `prod_acc`+=`Product`, `count`+=1.
  - When `count` reaches `block_len`, next state is HOLD.
  - Idle cycles (`in_valid`=0) change nothing.
- HOLD:
  - `sum_acc`, `prod_acc`, `count` (=`block_len`) and `ovf` stay stable.
  - On output handshake: next state IDLE, `sum_acc`=`prod_acc`=`count`=0. `ovf` keeps its value until the next block's first accept.
  - `in_ready`=0 for the whole of HOLD, including the handshake cycle.
- `clear`:
  - In IDLE/ACCUM: next state IDLE; accumulators, `count` and `ovf` are zeroed. `clear` beats a simultaneous accept, and the offered pair is dropped.
  - In HOLD: ignored. A completed result must be consumed.
- Priority: `rst` > `clear` > accept.
- Arithmetic is unsigned. A carry out of SW or PW bits sets `ovf`. The result value follows the Configuration section.

## Timing
- Reset values (from the edge where `rst`=1): state IDLE, `sum_acc`=0, `prod_acc`=0, `count`=0, `ovf`=0, `out_valid`=0, `in_ready`=1.
- Pairs offered while `rst`=1 are ignored.
- Throughput: one pair per cycle inside a block.
- Latency: last pair accepted at edge k gives `out_valid`=1 and the final totals from edge k onward (visible in cycle k+1).
- After the output handshake at edge h, `in_ready`=1 from edge h onward. Minimum block period is `block_len`+1 cycles.
- `rst` mid-block or in HOLD: everything returns to reset values at that edge, and the pending result is lost.
- All outputs except `in_ready` come straight from registers.

## Configuration
- `ARITH_ACC_SAT_EN` defined: each accumulator saturates at all-ones (2^SW−1 / 2^PW−1) and stays there for the rest of the block. `ovf`=1.
- `ARITH_ACC_SAT_EN` undefined: accumulators wrap modulo 2^SW / 2^PW. `ovf` is still set on carry-out, as detection only.

## Test plan
- Full block, size_adder=8, size_mult=6, block_len=4, guard=2, no stalls:
  - Stimulus: Sum 79, 510, 134, 400 with Product 500, 1200, 300, 800.
  - Required: after the 4th accept, `sum_acc`=1123, `prod_acc`=2800, `count`=4, `ovf`=0, `out_valid`=1.
- Backpressure after a full block:
  - Stimulus: `out_ready`=0 for 5 cycles, then 1.
  - Required: `out_valid`, `sum_acc`, `prod_acc` stable and `in_ready`=0 throughout; after the handshake, `in_ready`=1, `out_valid`=0, totals 0.
- Overflow, guard=1:
  - Stimulus: 4× (Sum=511, Product=4095).
  - With the macro: `sum_acc`=1023, `prod_acc`=8191, `ovf`=1.
  - Without the macro: `sum_acc`=1020, `prod_acc`=8188, `ovf`=1.
- `clear` after 2 accepts, asserted together with `in_valid`=1:
  - Required: `count`=0 and accumulators 0 next cycle; the pair is dropped; the next 4 pairs produce only their own totals.
- `rst` in ACCUM (count=3) and separately in HOLD:
  - Required: all outputs at reset values the following cycle, `in_ready`=1.
- Bubbles:
  - Stimulus: `in_valid` alternating 1/0 over 8 cycles.
  - Required: `count` steps only on accepts; `out_valid` rises after the 4th accept (cycle 8).

Source files
------------

// File: rtl/arith_accum.sv
// Block accumulator for the arith Sum/Product stream: totals over block_len pairs, held until taken.
// Define ARITH_ACC_SAT_EN to saturate the totals on carry-out instead of wrapping.
module arith_accum #(
  parameter int size_adder = 4,
  parameter int size_mult  = 4,
  parameter int block_len  = 4,
  parameter int guard      = 2,
  localparam int SW = size_adder + 1 + guard,
  localparam int PW = 2 * size_mult + guard,
  localparam int CW = $clog2(block_len) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [size_adder:0]     Sum,
  input  logic [2*size_mult-1:0]  Product,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SW-1:0]           sum_acc,
  output logic [PW-1:0]           prod_acc,
  output logic [CW-1:0]           count,
  output logic                    ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state;
  logic [SW-1:0] sum_base;
  logic [PW-1:0] prod_base;
  logic [SW:0]   sum_nxt;
  logic [PW:0]   prod_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_base;

  function automatic logic [SW-1:0] fit_sum(input logic [SW:0] v);
`ifdef ARITH_ACC_SAT_EN
    return v[SW] ? {SW{1'b1}} : v[SW-1:0];
`else
    return v[SW-1:0];
`endif
  endfunction

  function automatic logic [PW-1:0] fit_prod(input logic [PW:0] v);
`ifdef ARITH_ACC_SAT_EN
    return v[PW] ? {PW{1'b1}} : v[PW-1:0];
`else
    return v[PW-1:0];
`endif
  endfunction

  assign in_ready = (state != HOLD);

  // The first pair of a block starts from zero, so IDLE ignores whatever the registers still hold.
  assign sum_base  = (state == IDLE) ? '0 : sum_acc;
  assign prod_base = (state == IDLE) ? '0 : prod_acc;
  assign ovf_base  = (state == IDLE) ? 1'b0 : ovf;
  assign sum_nxt   = {1'b0, sum_base} + {{(guard + 1){1'b0}}, Sum};
  assign prod_nxt  = {1'b0, prod_base} + {{(guard + 1){1'b0}}, Product};
  assign cnt_nxt   = ((state == IDLE) ? '0 : count) + 1'b1;

  // ---- register stage: state, totals and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum_acc   <= '0;
      prod_acc  <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            state    <= IDLE;
            sum_acc  <= '0;
            prod_acc <= '0;
            count    <= '0;
            ovf      <= 1'b0;
          end else if (in_valid) begin
            sum_acc  <= fit_sum(sum_nxt);
            prod_acc <= fit_prod(prod_nxt);
            count    <= cnt_nxt;
            ovf      <= ovf_base | sum_nxt[SW] | prod_nxt[PW];
            if (cnt_nxt == CW'(block_len)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum_acc   <= '0;
            prod_acc  <= '0;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_accum.sv
// Directed bench for arith_accum: block totals, backpressure, bubbles, clear, reset and overflow.
module tb_arith_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: guard=2, no overflow expected.
  logic        a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_ovf;
  logic [8:0]  a_sum;
  logic [11:0] a_prod;
  logic [10:0] a_sum_acc;
  logic [13:0] a_prod_acc;
  logic [2:0]  a_count;

  // Instance B: guard=1, used for the overflow case.
  logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_ovf;
  logic [8:0]  b_sum;
  logic [11:0] b_prod;
  logic [9:0]  b_sum_acc;
  logic [12:0] b_prod_acc;
  logic [2:0]  b_count;

  arith_accum #(.size_adder(8), .size_mult(6), .block_len(4), .guard(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .Sum(a_sum), .Product(a_prod), .clear(a_clear), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sum_acc(a_sum_acc), .prod_acc(a_prod_acc),
    .count(a_count), .ovf(a_ovf));

  arith_accum #(.size_adder(8), .size_mult(6), .block_len(4), .guard(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Sum(b_sum), .Product(b_prod), .clear(b_clear), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum_acc(b_sum_acc), .prod_acc(b_prod_acc),
    .count(b_count), .ovf(b_ovf));

  typedef struct {
    logic v;
    int   s;
    int   p;
    int   es;
    int   ep;
    int   ec;
    int   eovf;
    int   eov;
  } vec_t;

  vec_t tbl[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, " sum_acc"},   int'(a_sum_acc),   0);
    chk({tag, " prod_acc"},  int'(a_prod_acc),  0);
    chk({tag, " count"},     int'(a_count),     0);
    chk({tag, " ovf"},       int'(a_ovf),       0);
    chk({tag, " out_valid"}, int'(a_out_valid), 0);
    chk({tag, " in_ready"},  int'(a_in_ready),  1);
  endtask

  task automatic push_a(input int s, input int p);
    a_in_valid = 1'b1; a_sum = 9'(s); a_prod = 12'(p);
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic push_b(input int s, input int p);
    b_in_valid = 1'b1; b_sum = 9'(s); b_prod = 12'(p);
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic handshake_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      a_in_valid = tbl[i].v; a_sum = 9'(tbl[i].s); a_prod = 12'(tbl[i].p);
      tick();
      chk($sformatf("%s[%0d] sum_acc", tag, i),   int'(a_sum_acc),   tbl[i].es);
      chk($sformatf("%s[%0d] prod_acc", tag, i),  int'(a_prod_acc),  tbl[i].ep);
      chk($sformatf("%s[%0d] count", tag, i),     int'(a_count),     tbl[i].ec);
      chk($sformatf("%s[%0d] ovf", tag, i),       int'(a_ovf),       tbl[i].eovf);
      chk($sformatf("%s[%0d] out_valid", tag, i), int'(a_out_valid), tbl[i].eov);
    end
    a_in_valid = 1'b0;
  endtask

  initial begin
    // Full block, no stalls.
    tbl[0]  = '{1'b1,  79,  500,   79,  500, 1, 0, 0};
    tbl[1]  = '{1'b1, 510, 1200,  589, 1700, 2, 0, 0};
    tbl[2]  = '{1'b1, 134,  300,  723, 2000, 3, 0, 0};
    tbl[3]  = '{1'b1, 400,  800, 1123, 2800, 4, 0, 1};
    // Bubbles: in_valid alternating 1/0 over 8 cycles.
    tbl[4]  = '{1'b1,  10,  100,   10,  100, 1, 0, 0};
    tbl[5]  = '{1'b0, 111,  111,   10,  100, 1, 0, 0};
    tbl[6]  = '{1'b1,  20,  200,   30,  300, 2, 0, 0};
    tbl[7]  = '{1'b0, 111,  111,   30,  300, 2, 0, 0};
    tbl[8]  = '{1'b1,  30,  300,   60,  600, 3, 0, 0};
    tbl[9]  = '{1'b0, 111,  111,   60,  600, 3, 0, 0};
    tbl[10] = '{1'b1,  40,  400,  100, 1000, 4, 0, 1};
    tbl[11] = '{1'b0, 111,  111,  100, 1000, 4, 0, 1};

    a_in_valid = 1'b1; a_sum = 9'd5; a_prod = 12'd5; a_clear = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_sum = 9'd5; b_prod = 12'd5; b_clear = 1'b0; b_out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    chk_a_reset("reset");

    run_rows(0, 3, "block");
    chk("block in_ready", int'(a_in_ready), 0);

    // Held result under backpressure; offered pairs must be ignored.
    a_in_valid = 1'b1; a_sum = 9'd5; a_prod = 12'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp out_valid", int'(a_out_valid), 1);
      chk("bp sum_acc",   int'(a_sum_acc),   1123);
      chk("bp prod_acc",  int'(a_prod_acc),  2800);
      chk("bp count",     int'(a_count),     4);
      chk("bp in_ready",  int'(a_in_ready),  0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("hs-cycle in_ready", int'(a_in_ready), 0);
    tick();
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    chk_a_reset("after hs");

    run_rows(4, 11, "bubble");
    handshake_a();

    // clear with a simultaneous offer drops the pair.
    push_a(100, 1000);
    push_a(200, 2000);
    chk("pre-clear count", int'(a_count), 2);
    a_clear = 1'b1; a_in_valid = 1'b1; a_sum = 9'd7; a_prod = 12'd7;
    tick();
    a_clear = 1'b0; a_in_valid = 1'b0;
    chk_a_reset("clear");
    push_a(1, 10);
    push_a(2, 20);
    push_a(3, 30);
    push_a(4, 40);
    chk("post-clear sum_acc",   int'(a_sum_acc),   10);
    chk("post-clear prod_acc",  int'(a_prod_acc),  100);
    chk("post-clear count",     int'(a_count),     4);
    chk("post-clear out_valid", int'(a_out_valid), 1);
    handshake_a();

    // clear is ignored in HOLD.
    push_a(1, 1); push_a(1, 1); push_a(1, 1); push_a(1, 1);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("hold-clear out_valid", int'(a_out_valid), 1);
    chk("hold-clear sum_acc",   int'(a_sum_acc),   4);
    handshake_a();

    // rst mid-block (count=3) and in HOLD.
    push_a(50, 60); push_a(50, 60); push_a(50, 60);
    chk("pre-rst count", int'(a_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a_reset("rst accum");
    push_a(50, 60); push_a(50, 60); push_a(50, 60); push_a(50, 60);
    chk("pre-rst out_valid", int'(a_out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a_reset("rst hold");

    // Overflow with guard=1.
    push_b(511, 4095);
    push_b(511, 4095);
    chk("ovf2 ovf",      int'(b_ovf),      0);
    chk("ovf2 sum_acc",  int'(b_sum_acc),  1022);
    chk("ovf2 prod_acc", int'(b_prod_acc), 8190);
    push_b(511, 4095);
    chk("ovf3 ovf", int'(b_ovf), 1);
`ifdef ARITH_ACC_SAT_EN
    chk("ovf3 sum_acc",  int'(b_sum_acc),  1023);
    chk("ovf3 prod_acc", int'(b_prod_acc), 8191);
`else
    chk("ovf3 sum_acc",  int'(b_sum_acc),  509);
    chk("ovf3 prod_acc", int'(b_prod_acc), 4093);
`endif
    push_b(511, 4095);
`ifdef ARITH_ACC_SAT_EN
    chk("ovf4 sum_acc",  int'(b_sum_acc),  1023);
    chk("ovf4 prod_acc", int'(b_prod_acc), 8191);
`else
    chk("ovf4 sum_acc",  int'(b_sum_acc),  1020);
    chk("ovf4 prod_acc", int'(b_prod_acc), 8188);
`endif
    chk("ovf4 ovf",       int'(b_ovf),       1);
    chk("ovf4 out_valid", int'(b_out_valid), 1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("ovf after hs",       int'(b_ovf),      1);
    chk("ovf-hs sum_acc",     int'(b_sum_acc),  0);
    chk("ovf-hs in_ready",    int'(b_in_ready), 1);
    push_b(1, 1);
    chk("ovf next block",     int'(b_ovf),      0);
    chk("next block sum_acc", int'(b_sum_acc),  1);
    chk("next block count",   int'(b_count),    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
